// File: rtl/pot_dot_accumulator_pkg.sv
// Shared widths and weight-field layout for the PoT dot-product datapath.
package pot_dot_accumulator_pkg;

  function automatic int prod_width(input int iw, input int ww);
    return iw + 2**ww;
  endfunction

  function automatic int acc_width(input int iw, input int ww, input int vl);
    return prod_width(iw, ww) + $clog2(vl);
  endfunction

  // Weight code: MSB is the sign, the bits below it are the shift amount.
  function automatic int sign_idx(input int ww);
    return ww - 1;
  endfunction

  function automatic int shamt_msb(input int ww);
    return ww - 2;
  endfunction

endpackage

// File: rtl/pot_dot_accumulator_pot_shift.sv
// Power-of-two weight multiplier: data scaled by 2**(2**W - shamt), optionally negated.
module pot_shift
  import pot_dot_accumulator_pkg::*;
#(
  parameter int WEIGHT_BIT_WIDTH = 4,
  parameter int INPUT_BIT_WIDTH  = 4,
  localparam int PROD_W = prod_width(INPUT_BIT_WIDTH, WEIGHT_BIT_WIDTH)
) (
  input  logic signed [INPUT_BIT_WIDTH-1:0]  data,
  input  logic        [WEIGHT_BIT_WIDTH-1:0] weight,
  output logic signed [PROD_W-1:0]           prod
);

  localparam int SHAMT_W = WEIGHT_BIT_WIDTH - 1;
  localparam int SHIFT_W = WEIGHT_BIT_WIDTH + 1;
  localparam logic [SHIFT_W-1:0] SHIFT_TOP = SHIFT_W'(2**WEIGHT_BIT_WIDTH);

  logic                     neg;
  logic [SHAMT_W-1:0]       shamt;
  logic [SHIFT_W-1:0]       shift;
  logic signed [PROD_W-1:0] data_ext;
  logic signed [PROD_W-1:0] mag;

  assign neg      = weight[sign_idx(WEIGHT_BIT_WIDTH)];
  assign shamt    = weight[shamt_msb(WEIGHT_BIT_WIDTH):0];
  assign shift    = SHIFT_TOP - SHIFT_W'(shamt);
  assign data_ext = $signed({{(PROD_W-INPUT_BIT_WIDTH){data[INPUT_BIT_WIDTH-1]}}, data});
  assign mag      = data_ext <<< shift;
  // Negating the most negative activation at full scale wraps in PROD_W bits.
  assign prod     = neg ? -mag : mag;

endmodule

// File: rtl/pot_dot_accumulator.sv
// Streams (activation, PoT weight) pairs, sums VECTOR_LENGTH products, and
// hands each dot product out through a one-entry valid/ready output register.
module pot_dot_accumulator
  import pot_dot_accumulator_pkg::*;
#(
  parameter int WEIGHT_BIT_WIDTH = 4,
  parameter int INPUT_BIT_WIDTH  = 4,
  parameter int VECTOR_LENGTH    = 16,
  localparam int PROD_W = prod_width(INPUT_BIT_WIDTH, WEIGHT_BIT_WIDTH),
  localparam int ACC_W  = acc_width(INPUT_BIT_WIDTH, WEIGHT_BIT_WIDTH, VECTOR_LENGTH)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic signed [INPUT_BIT_WIDTH-1:0]  in_data,
  input  logic        [WEIGHT_BIT_WIDTH-1:0] in_weight,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic signed [ACC_W-1:0]            out_data,
  output logic                               out_valid,
  input  logic                               out_ready
);

  localparam int CNT_W = $clog2(VECTOR_LENGTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VECTOR_LENGTH - 1);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic [CNT_W-1:0]         count;
  logic                     is_last;
  logic                     accept;

  pot_shift #(
    .WEIGHT_BIT_WIDTH(WEIGHT_BIT_WIDTH),
    .INPUT_BIT_WIDTH (INPUT_BIT_WIDTH)
  ) u_pot_shift (
    .data  (in_data),
    .weight(in_weight),
    .prod  (prod)
  );

  assign prod_ext = $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
  assign sum      = acc + prod_ext;
  assign is_last  = (count == LAST);
  // Only a last element needs the output register, so only it can stall.
  assign in_ready = !(is_last && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (is_last) begin
          out_data  <= sum;
          out_valid <= 1'b1;
          acc       <= '0;
          count     <= '0;
        end else begin
          acc   <= sum;
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pot_dot_accumulator.sv
// Self-checking bench for pot_dot_accumulator with W=2, IW=4, VL=4.
module tb_pot_dot_accumulator;

  localparam int WW = 2;
  localparam int IW = 4;
  localparam int VL = 4;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] in_data = '0;
  logic [WW-1:0] in_weight = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int m_cnt = 0;
  bit m_ov = 1'b0;

  typedef struct packed {
    logic [3:0][3:0] d;
    logic [3:0][1:0] w;
    int              gap;
    int              exp;
  } vec_t;

  vec_t vecs[5];

  pot_dot_accumulator #(
    .WEIGHT_BIT_WIDTH(WW),
    .INPUT_BIT_WIDTH (IW),
    .VECTOR_LENGTH   (VL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_weight(in_weight),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3,
                              input logic [1:0] w0, input logic [1:0] w1,
                              input logic [1:0] w2, input logic [1:0] w3,
                              input int gap, input int exp);
    vec_t v;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.gap = gap;
    v.exp = exp;
    return v;
  endfunction

  // One cycle of stimulus; the model tracks count and pending-output state
  // to predict in_ready, and queues exp_last when a last element is taken.
  task automatic drive(input logic v, input logic [3:0] d, input logic [1:0] w,
                       input logic ordy, input int exp_last);
    bit exp_ready;
    bit acc_now;
    @(posedge clk); #1;
    in_valid = v; in_data = d; in_weight = w; out_ready = ordy;
    @(negedge clk);
    exp_ready = !(m_cnt == VL-1 && m_ov && !ordy);
    check("in_ready", int'(in_ready), int'(exp_ready));
    acc_now = v && exp_ready;
    if (m_ov && ordy) m_ov = 1'b0;
    if (acc_now) begin
      if (m_cnt == VL-1) begin
        m_ov = 1'b1;
        m_cnt = 0;
        exp_q.push_back(exp_last);
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 2'd0, ordy, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; in_data = 4'd7; in_weight = 2'd0; out_ready = 1'b0;
    @(negedge clk);
    exp_q.delete();
    m_cnt = 0;
    m_ov = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_in_ready", int'(in_ready), 1);
  endtask

  task automatic send_basic(input logic ordy);
    drive(1'b1, 4'd3, 2'b00, ordy, 104);
    drive(1'b1, 4'd3, 2'b01, ordy, 104);
    drive(1'b1, 4'd1, 2'b00, ordy, 104);
    drive(1'b1, 4'd2, 2'b01, ordy, 104);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", int'($signed(out_data)), -9999);
      end else begin
        check("out_data", int'($signed(out_data)), exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = mk(4'd3, 4'd3, 4'd1, 4'd2, 2'b00, 2'b01, 2'b00, 2'b01, 0, 104);
    vecs[1] = mk(4'd3, 4'd3, 4'd1, 4'd0, 2'b10, 2'b11, 2'b00, 2'b00, 0, -56);
    vecs[2] = mk(4'd7, 4'd7, 4'd7, 4'd7, 2'b00, 2'b00, 2'b00, 2'b00, 2, 448);
    vecs[3] = mk(4'h8, 4'h8, 4'h8, 4'h8, 2'b00, 2'b00, 2'b00, 2'b00, 1, -512);
    vecs[4] = mk(4'hF, 4'd5, 4'hD, 4'd2, 2'b01, 2'b11, 2'b10, 2'b00, 0, 32);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("init_out_valid", int'(out_valid), 0);
    check("init_out_data", int'(out_data), 0);
    check("init_in_ready", int'(in_ready), 1);

    for (int v = 0; v < 5; v++) begin
      for (int e = 0; e < VL; e++) begin
        drive(1'b1, vecs[v].d[e], vecs[v].w[e], 1'b1, vecs[v].exp);
        idle(vecs[v].gap, 1'b1);
      end
    end
    idle(2, 1'b1);

    // Backpressure: first result held, second vector stalls on its last pair.
    send_basic(1'b0);
    drive(1'b1, 4'd3, 2'b10, 1'b0, -56);
    drive(1'b1, 4'd3, 2'b11, 1'b0, -56);
    drive(1'b1, 4'd1, 2'b00, 1'b0, -56);
    check("bp_held_valid", int'(out_valid), 1);
    check("bp_held_data", int'($signed(out_data)), 104);
    drive(1'b1, 4'd0, 2'b00, 1'b0, -56);
    drive(1'b1, 4'd0, 2'b00, 1'b0, -56);
    check("bp_stall_data", int'($signed(out_data)), 104);
    drive(1'b1, 4'd0, 2'b00, 1'b1, -56);
    @(posedge clk); #1;
    check("bp_valid_kept", int'(out_valid), 1);
    check("bp_data_updated", int'($signed(out_data)), -56);
    idle(2, 1'b1);

    // Reset mid-vector discards the partial sum.
    drive(1'b1, 4'd7, 2'b00, 1'b1, 0);
    drive(1'b1, 4'd7, 2'b00, 1'b1, 0);
    do_reset();
    send_basic(1'b1);
    idle(2, 1'b1);

    // Reset with a pending result drops it.
    send_basic(1'b0);
    idle(1, 1'b0);
    check("pend_out_valid", int'(out_valid), 1);
    do_reset();
    idle(3, 1'b1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
